// File: rtl/fp_addsub_scheduler.sv
// rtl/fp_addsub_scheduler.sv - round-robin scheduler sharing one FP32 add/sub datapath
// Optional FP_ADDSUB_FLAGS_EN adds rsp_flags {nan, inf, zero, denorm}.

module ieee_754_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        swap, sign_big, eff_sub, nan_a, nan_b, inf_a, inf_b, rnd;
  logic [7:0]  ea, eb, e_big, e_sml, d, dc;
  logic [23:0] m_big, m_sml;
  logic [50:0] align;
  logic [26:0] op_big, op_sml, n;
  logic [27:0] s;
  logic [4:0]  lz, shamt;
  logic [9:0]  e;
  logic [24:0] m;

  always_comb begin
    ea      = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb      = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    nan_a   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    swap    = b[30:0] > a[30:0];
    eff_sub = a[31] ^ b[31];
    sign_big = swap ? b[31] : a[31];
    e_big   = swap ? eb : ea;
    e_sml   = swap ? ea : eb;
    m_big   = swap ? {b[30:23] != 8'd0, b[22:0]} : {a[30:23] != 8'd0, a[22:0]};
    m_sml   = swap ? {a[30:23] != 8'd0, a[22:0]} : {b[30:23] != 8'd0, b[22:0]};
    d       = e_big - e_sml;
    dc      = (d > 8'd30) ? 8'd30 : d;
    // Shifted-out bits of the smaller operand collapse into a sticky lsb.
    align   = {m_sml, 27'd0} >> dc;
    op_sml  = align[50:24] | {26'd0, |align[23:0]};
    op_big  = {m_big, 3'b000};
    s       = eff_sub ? ({1'b0, op_big} - {1'b0, op_sml}) : ({1'b0, op_big} + {1'b0, op_sml});
    e       = {2'b00, e_big};
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      n = s[26:0];
    end
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (n[i]) lz = 5'(26 - i);
    end
    // Normalisation stops at the minimum exponent, leaving a subnormal.
    shamt = ({5'd0, lz} < (e - 10'd1)) ? lz : 5'(e - 10'd1);
    n     = n << shamt;
    e     = e - {5'd0, shamt};
    rnd   = n[2] & (n[1] | n[0] | n[3]);
    m     = {1'b0, n[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) y = {sign_big, 8'hFF, 23'd0};
    else              y = {sign_big, m[23] ? e[7:0] : 8'd0, m[22:0]};
    if (s == 28'd0) y = {a[31] & b[31], 31'd0};
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) y = 32'h7FC00000;
    else if (inf_a) y = a;
    else if (inf_b) y = b;
  end
endmodule

module fp_addsub_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_result,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
`ifdef FP_ADDSUB_FLAGS_EN
  ,
  output logic [3:0]            rsp_flags
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, id_q;
  logic            grant_found, op_q;
  logic [31:0]     a_q, b_q, sum;
  int              idx;

  ieee_754_adder u_adder (
    .a (a_q),
    .b ({b_q[31] ^ op_q, b_q[30:0]}),
    .y (sum)
  );

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: if (grant_found) begin
        req_ready[grant] = 1'b1;
        state_nxt        = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Keep ready low while reset is asserted even though state already reads IDLE.
    if (rst) req_ready = '0;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      id_q       <= '0;
      rsp_result <= '0;
      rsp_id     <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
      rsp_flags  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (grant_found) begin
          a_q  <= req_a[32*int'(grant) +: 32];
          b_q  <= req_b[32*int'(grant) +: 32];
          op_q <= req_op[grant];
          id_q <= grant;
        end
        EXEC: begin
          rsp_result <= sum;
          rsp_id     <= id_q;
`ifdef FP_ADDSUB_FLAGS_EN
          rsp_flags  <= {(sum[30:23] == 8'hFF) && (sum[22:0] != 23'd0),
                         (sum[30:23] == 8'hFF) && (sum[22:0] == 23'd0),
                         (sum[30:23] == 8'h00) && (sum[22:0] == 23'd0),
                         (sum[30:23] == 8'h00) && (sum[22:0] != 23'd0)};
`endif
        end
        RESP: if (rsp_ready) begin
          // Pointer moves past the requester just served.
          rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// tb/tb_fp_addsub_scheduler.sv - directed self-checking bench for fp_addsub_scheduler
module tb_fp_addsub_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_op = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [31:0]           rsp_result;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]            rsp_flags;
`endif

  int checks = 0;
  int errors = 0;

  fp_addsub_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    .rsp_flags  (rsp_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
  endtask

  task automatic run_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp_r, input int stall,
                         input logic [3:0] exp_flags);
    int n;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_op[idx] = op;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("grant", 32'(req_ready), 32'(1 << idx));
    @(posedge clk); #1;
    req_valid = '0;
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_req_ready", 32'(req_ready), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_result", rsp_result, exp_r);
    check("resp_id", 32'(rsp_id), 32'(idx));
`ifdef FP_ADDSUB_FLAGS_EN
    check("resp_flags", 32'(rsp_flags), 32'(exp_flags));
`else
    if (exp_flags != 4'hF) n = 0;
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_result", rsp_result, exp_r);
      check("stall_id", 32'(rsp_id), 32'(idx));
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int grants[5];
    int ng;
    int cyc;
    logic seen_valid;

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    req_valid = 4'b0101;
    #1;
    check("reset_ready_gated", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 4'b0000);
    run_txn(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 0, 4'b0000);
    run_txn(1, 32'h40400000, 32'h40000000, 1'b0, 32'h40A00000, 5, 4'b0000);
    run_txn(3, 32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 0, 4'b0000);

    // Reset during EXEC
    req_valid = 4'b1000;
    req_a[96 +: 32] = 32'h3F800000;
    req_b[96 +: 32] = 32'h3F800000;
    req_op[3] = 1'b0;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("post_rst_no_rsp", 32'(seen_valid), 32'd0);

    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = 32'h3F800000;
      req_b[32*i +: 32] = 32'h3F800000;
      req_op[i] = 1'b0;
    end
    req_valid = 4'b1001;
    #1;
    check("post_rst_grant0", 32'(req_ready), 32'b0001);

    // Round-robin with all requesters valid
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    ng = 0;
    cyc = 0;
    while (ng < 5 && cyc < 60) begin
      if (busy) begin
        check("rr_ready_when_busy", 32'(req_ready), 32'd0);
      end else begin
        check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < NUM_REQ; i++)
          if (req_ready[i]) grants[ng] = i;
        ng++;
      end
      if (rsp_valid) check("rr_result", rsp_result, 32'h40000000);
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = '0;
    check("rr_grant_count", 32'(ng), 32'd5);
    check("rr_g0", 32'(grants[0]), 32'd0);
    check("rr_g1", 32'(grants[1]), 32'd1);
    check("rr_g2", 32'(grants[2]), 32'd2);
    check("rr_g3", 32'(grants[3]), 32'd3);
    check("rr_g4", 32'(grants[4]), 32'd0);
    cyc = 0;
    while (busy && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rr_drain_idle", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

`ifdef FP_ADDSUB_FLAGS_EN
    run_txn(1, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 0, 4'b0100);
    run_txn(2, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 0, 4'b0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
